hsv2rgb_pipe: RTL and testbench

- Pipelined HSV-to-RGB converter: the inverse path of the camera-side RGB-to-HSV stage, feeding the overlay/display path after HSV-domain colour processing (thresholding, hue shifting).
- Accepts one 24-bit HSV pixel per pclk with a valid strobe.
- Produces one 24-bit RGB888 pixel with fixed latency 4; no back-pressure.
- HSV packing: H[23:16] = hue/2 (0..179), S[15:8] = 0..255, V[7:0] = 0..255.

---
 rtl/hsv2rgb_pipe.sv | 105 ++++++++++
 tb/tb_hsv2rgb_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: 4-stage HSV (H/2, S, V) to RGB888 converter with floor-exact constant division.
// Define HSV2RGB_SYNC_DELAY_EN to carry {vsync, hsync, de} alongside the pixel as sync_in/sync_out.
module hsv2rgb_pipe #(
   parameter int LATENCY = 4
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [23:0] HSV24,
`ifdef HSV2RGB_SYNC_DELAY_EN
   input  logic [2:0]  sync_in,
   output logic [2:0]  sync_out,
`endif
   output logic        out_valid,
   output logic [23:0] RGB24
);
   logic [LATENCY-1:0] vld;
   logic [7:0]  h_w;
   logic [2:0]  sec_w;
   logic [4:0]  rem_w;
   logic [7:0]  s1, v1;
   logic [2:0]  sec1;
   logic [5:0]  f1;
   logic [13:0] a2, b2;
   logic [7:0]  c2, v2;
   logic [2:0]  sec2;
   logic [7:0]  p3, q3, t3, v3;
   logic [2:0]  sec3;
   logic [15:0] p_num;
   logic [21:0] q_num, t_num;
   logic [23:0] rgb_w;

   always_comb begin
      h_w   = HSV24[23:16] >= 8'd180 ? HSV24[23:16] - 8'd180 : HSV24[23:16];
      sec_w = h_w >= 8'd150 ? 3'd5 : h_w >= 8'd120 ? 3'd4 : h_w >= 8'd90 ? 3'd3 :
              h_w >= 8'd60 ? 3'd2 : h_w >= 8'd30 ? 3'd1 : 3'd0;
      rem_w = 5'(h_w - {5'd0, sec_w} * 8'd30);
      p_num = {8'd0, v2} * {8'd0, c2};
      q_num = {14'd0, v2} * (22'd15300 - {8'd0, a2});
      t_num = {14'd0, v2} * (22'd15300 - {8'd0, b2});
      rgb_w = sec3 == 3'd0 ? {v3, t3, p3} :
              sec3 == 3'd1 ? {q3, v3, p3} :
              sec3 == 3'd2 ? {p3, v3, t3} :
              sec3 == 3'd3 ? {p3, q3, v3} :
              sec3 == 3'd4 ? {t3, p3, v3} : {v3, p3, q3};
   end

   // every data stage loads only when its own valid bit is set, so idle cycles hold the last pixel
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vld   <= '0;
         s1    <= '0;
         v1    <= '0;
         sec1  <= '0;
         f1    <= '0;
         a2    <= '0;
         b2    <= '0;
         c2    <= '0;
         v2    <= '0;
         sec2  <= '0;
         p3    <= '0;
         q3    <= '0;
         t3    <= '0;
         v3    <= '0;
         sec3  <= '0;
         RGB24 <= '0;
      end else begin
         vld <= {vld[LATENCY-2:0], in_valid};
         if (in_valid) begin
            s1   <= HSV24[15:8];
            v1   <= HSV24[7:0];
            sec1 <= sec_w;
            f1   <= {rem_w, 1'b0};
         end
         if (vld[0]) begin
            a2   <= {6'd0, s1} * {8'd0, f1};
            b2   <= {6'd0, s1} * (14'd60 - {8'd0, f1});
            c2   <= 8'd255 - s1;
            v2   <= v1;
            sec2 <= sec1;
         end
         if (vld[1]) begin
            p3   <= 8'(p_num / 16'd255);
            q3   <= 8'(q_num / 22'd15300);
            t3   <= 8'(t_num / 22'd15300);
            v3   <= v2;
            sec3 <= sec2;
         end
         if (vld[2]) RGB24 <= rgb_w;
      end
   end

   assign out_valid = vld[LATENCY-1];

`ifdef HSV2RGB_SYNC_DELAY_EN
   logic [LATENCY-1:0][2:0] sd;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) sd <= '0;
      else sd <= {sd[LATENCY-2:0], sync_in};
   end

   assign sync_out = sd[LATENCY-1];
`endif
endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// tb_hsv2rgb_pipe: directed and swept checks of hsv2rgb_pipe against hand values and a floor-division model.
module tb_hsv2rgb_pipe;
   logic        pclk;
   logic        rst_n;
   logic        in_valid;
   logic [23:0] HSV24;
   logic        out_valid;
   logic [23:0] RGB24;
   logic [2:0]  sync_in;
`ifdef HSV2RGB_SYNC_DELAY_EN
   logic [2:0]  sync_out;
`endif
   int n_tests, n_fail;
   logic        pv[4];
   logic [23:0] pr[4];
   logic [2:0]  ps[4];
   string       pt[4];
   logic [23:0] cur;
   logic [2:0]  scnt;
   int sl[6] = '{0, 1, 37, 128, 254, 255};
   int vl[5] = '{0, 1, 99, 200, 255};

   hsv2rgb_pipe dut (
      .pclk(pclk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .HSV24(HSV24),
`ifdef HSV2RGB_SYNC_DELAY_EN
      .sync_in(sync_in),
      .sync_out(sync_out),
`endif
      .out_valid(out_valid),
      .RGB24(RGB24)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_rgb(input logic [23:0] hsv);
      int h, s, v, f, p, q, t;
      h = int'(hsv[23:16]);
      s = int'(hsv[15:8]);
      v = int'(hsv[7:0]);
      if (h >= 180) h -= 180;
      f = 2 * (h % 30);
      p = v * (255 - s) / 255;
      q = v * (15300 - s * f) / 15300;
      t = v * (15300 - s * (60 - f)) / 15300;
      case (h / 30)
         0: return {8'(v), 8'(t), 8'(p)};
         1: return {8'(q), 8'(v), 8'(p)};
         2: return {8'(p), 8'(v), 8'(t)};
         3: return {8'(p), 8'(q), 8'(v)};
         4: return {8'(t), 8'(p), 8'(v)};
         default: return {8'(v), 8'(p), 8'(q)};
      endcase
   endfunction

   task automatic clear_pipe();
      for (int i = 0; i < 4; i++) begin
         pv[i] = 1'b0;
         pr[i] = '0;
         ps[i] = '0;
         pt[i] = "idle";
      end
      cur = '0;
   endtask

   // drive one input at a negedge, then check the pixel that entered three calls earlier
   task automatic cyc(input logic v, input logic [23:0] hsv, input logic [23:0] e, input string tag);
      in_valid = v;
      HSV24    = hsv;
      sync_in  = scnt;
      @(negedge pclk);
      for (int i = 3; i > 0; i--) begin
         pv[i] = pv[i-1];
         pr[i] = pr[i-1];
         ps[i] = ps[i-1];
         pt[i] = pt[i-1];
      end
      pv[0] = v;
      pr[0] = e;
      ps[0] = scnt;
      pt[0] = tag;
      scnt  = scnt + 3'd1;
      if (pv[3]) cur = pr[3];
      chk({pt[3], "/valid"}, {23'd0, out_valid}, {23'd0, pv[3]});
      chk({pt[3], "/rgb"}, RGB24, cur);
`ifdef HSV2RGB_SYNC_DELAY_EN
      chk({pt[3], "/sync"}, {21'd0, sync_out}, {21'd0, ps[3]});
`endif
   endtask

   task automatic flush();
      repeat (4) cyc(1'b0, 24'h0, 24'h0, "idle");
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      scnt     = 3'd0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      HSV24    = '0;
      sync_in  = 3'd0;
      clear_pipe();
      repeat (2) @(negedge pclk);
      chk("reset/valid", {23'd0, out_valid}, 24'd0);
      chk("reset/rgb", RGB24, 24'h000000);
`ifdef HSV2RGB_SYNC_DELAY_EN
      chk("reset/sync", {21'd0, sync_out}, 24'd0);
`endif
      rst_n = 1'b1;
      cyc(1'b1, 24'h00FFFF, 24'hFF0000, "red");
      cyc(1'b1, 24'h3CFFFF, 24'h00FF00, "green");
      cyc(1'b1, 24'h78FFFF, 24'h0000FF, "blue");
      cyc(1'b1, 24'h5A0080, 24'h808080, "grey");
      cyc(1'b1, 24'h2AFF00, 24'h000000, "black");
      cyc(1'b1, 24'h0FFFFF, 24'hFF7F00, "h30");
      cyc(1'b1, 24'hC8FFFF, 24'hFFAA00, "wrap200");
      flush();
      cyc(1'b1, 24'h00FFFF, 24'hFF0000, "gap0");
      cyc(1'b0, 24'h3CFFFF, 24'h00FF00, "gap1");
      cyc(1'b1, 24'h78FFFF, 24'h0000FF, "gap2");
      cyc(1'b1, 24'h0FFFFF, 24'hFF7F00, "gap3");
      cyc(1'b0, 24'h5A0080, 24'h808080, "gap4");
      flush();
      cyc(1'b1, 24'h0FFFFF, 24'hFF7F00, "pre");
      flush();
      cyc(1'b1, 24'h00FFFF, 24'hFF0000, "stale0");
      cyc(1'b1, 24'h3CFFFF, 24'h00FF00, "stale1");
      cyc(1'b1, 24'h78FFFF, 24'h0000FF, "stale2");
      #2 rst_n = 1'b0;
      #1;
      chk("midrst/valid", {23'd0, out_valid}, 24'd0);
      chk("midrst/rgb", RGB24, 24'h000000);
`ifdef HSV2RGB_SYNC_DELAY_EN
      chk("midrst/sync", {21'd0, sync_out}, 24'd0);
`endif
      clear_pipe();
      @(negedge pclk);
      rst_n = 1'b1;
      repeat (6) cyc(1'b0, 24'h00FFFF, 24'h0, "postrst");
      cyc(1'b1, 24'hC8FFFF, 24'hFFAA00, "fresh");
      flush();
      for (int h = 0; h < 256; h++)
         for (int si = 0; si < 6; si++)
            for (int vi = 0; vi < 5; vi++) begin
               logic [23:0] x;
               x = {8'(h), 8'(sl[si]), 8'(vl[vi])};
               cyc(1'b1, x, ref_rgb(x), $sformatf("sweep%h", x));
            end
      for (int k = 0; k < 1500; k++) begin
         logic [23:0] x;
         x = {8'($urandom_range(0, 179)), 8'($urandom), 8'($urandom)};
         cyc(1'b1, x, ref_rgb(x), $sformatf("rand%h", x));
      end
      flush();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
